regfile_dump_reader: RTL and testbench

//   Read-side dump engine for the 32x32 CPU register file. On a start pulse it walks

---
 rtl/regfile_dump_reader.sv | 98 +++++++++
 tb/tb_regfile_dump_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Register file dump engine.
// Walks the register indices in order and drives the spare combinational read port.
// Each {index, value} is presented as one beat on a valid/ready stream.
// The engine does not stall datapath writes. A write that lands on the same edge
// as the capture is not seen, because the read data is sampled before that edge.
module regfile_dump_reader #(
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 32,
   parameter bit          SKIP_ZERO = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_index,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic              busy,
   output logic              done
);

   // x0 is hardwired to zero, so the walk may begin at index 1.
   localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_ZERO ? ADDR_W'(1) : '0;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StSend,
      StDone
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] idx_q;

   // Walk FSM. Every output is registered, so consumers see glitch-free beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         rd_addr    <= '0;
         dump_valid <= 1'b0;
         dump_index <= '0;
         dump_data  <= '0;
         dump_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               rd_addr <= '0;
               if (start) begin
                  idx_q   <= FIRST_IDX;
                  rd_addr <= FIRST_IDX;
                  busy    <= 1'b1;
                  state_q <= StRead;
               end
            end
            StRead: begin
               // rd_addr has been stable for this whole cycle, so rd_data is the snapshot.
               dump_data  <= rd_data;
               dump_index <= idx_q;
               dump_last  <= (idx_q == LAST_IDX);
               dump_valid <= 1'b1;
               state_q    <= StSend;
            end
            StSend: begin
               // dump_valid is always high here. The beat holds until it is accepted.
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  if (dump_last) begin
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     rd_addr <= idx_q + 1'b1;
                     state_q <= StRead;
                  end
               end
            end
            StDone: begin
               busy    <= 1'b0;
               rd_addr <= '0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a regfile model, a scoreboard of expected beats,
// and a table of dump scenarios. u_dut0 walks from x0; u_dut1 skips x0.
module tb_regfile_dump_reader;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      int sel;
      int mode;   // 0 ready=1, 1 random ready, 2 stall idx7, 3 write x5, 4 reset idx12, 5 start spam
      int pat;    // 0 0x1000_0000+i, 1 random
      int exp_beats;
      int exp_dones;
      int exp_first;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  start = '0;
   logic [1:0]  ready = '0;
   logic [4:0]  rd_addr [2];
   logic [31:0] rd_data [2];
   logic [1:0]  dump_valid;
   logic [1:0]  dump_last;
   logic [1:0]  busy;
   logic [1:0]  done;
   logic [4:0]  dump_index [2];
   logic [31:0] dump_data [2];

   logic [31:0] regs [32];
   logic [31:0] pre [32];
   logic        load = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;

   int    ntests = 0;
   int    nfail = 0;
   beat_t exp_q0[$];
   beat_t exp_q1[$];
   int    beat_cnt [2];
   int    done_cnt [2];
   int    first_idx [2];
   logic [1:0] done_due;

   always #5 clk = ~clk;

   // Regfile model: preload or single write port, with a combinational read and x0 hardwired to 0.
   always @(posedge clk) begin
      if (load) begin
         for (int r = 0; r < 32; r++) regs[r] <= pre[r];
      end else if (wr_en && wr_addr != 5'd0) begin
         regs[wr_addr] <= wr_data;
      end
   end
   assign rd_data[0] = (rd_addr[0] == 5'd0) ? 32'd0 : regs[rd_addr[0]];
   assign rd_data[1] = (rd_addr[1] == 5'd0) ? 32'd0 : regs[rd_addr[1]];

   regfile_dump_reader #(
      .NUM_REGS (32),
      .ADDR_W   (5),
      .DATA_W   (32),
      .SKIP_ZERO(1'b0)
   ) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .start     (start[0]),
      .rd_addr   (rd_addr[0]),
      .rd_data   (rd_data[0]),
      .dump_valid(dump_valid[0]),
      .dump_ready(ready[0]),
      .dump_index(dump_index[0]),
      .dump_data (dump_data[0]),
      .dump_last (dump_last[0]),
      .busy      (busy[0]),
      .done      (done[0])
   );

   regfile_dump_reader #(
      .NUM_REGS (32),
      .ADDR_W   (5),
      .DATA_W   (32),
      .SKIP_ZERO(1'b1)
   ) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start[1]),
      .rd_addr   (rd_addr[1]),
      .rd_data   (rd_data[1]),
      .dump_valid(dump_valid[1]),
      .dump_ready(ready[1]),
      .dump_index(dump_index[1]),
      .dump_data (dump_data[1]),
      .dump_last (dump_last[1]),
      .busy      (busy[1]),
      .done      (done[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic void push_exp(input int sel, input beat_t b);
      if (sel == 0) exp_q0.push_back(b);
      else exp_q1.push_back(b);
   endfunction

   function automatic bit pop_exp(input int sel, output beat_t b);
      b = '0;
      if (sel == 0) begin
         if (exp_q0.size() == 0) return 1'b0;
         b = exp_q0.pop_front();
      end else begin
         if (exp_q1.size() == 0) return 1'b0;
         b = exp_q1.pop_front();
      end
      return 1'b1;
   endfunction

   function automatic int qsize(input int sel);
      return (sel == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   // Monitor: checks accepted beats against the scoreboard, and that done pulses once after the last beat.
   always @(negedge clk) begin
      beat_t got;
      beat_t want;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            done_due[i] = 1'b0;
         end else begin
            check($sformatf("done_pulse%0d", i), done[i], done_due[i]);
            if (done[i]) done_cnt[i]++;
            done_due[i] = 1'b0;
            if (dump_valid[i]) check($sformatf("busy_with_valid%0d", i), busy[i], 1);
            if (dump_valid[i] && ready[i]) begin
               if (beat_cnt[i] == 0) first_idx[i] = int'(dump_index[i]);
               beat_cnt[i]++;
               done_due[i] = dump_last[i];
               got = '{idx: dump_index[i], data: dump_data[i], last: dump_last[i]};
               if (!pop_exp(i, want)) begin
                  ntests++;
                  nfail++;
                  $display("FAIL unexpected_beat%0d: got idx %0d data 0x%0h, required no beat",
                           i, got.idx, got.data);
               end else begin
                  check($sformatf("beat%0d_idx%0d", i, want.idx), got, want);
               end
            end
         end
      end
   end

   task automatic run_dump(input vec_t v);
      int          s;
      int          hold;
      int          cyc;
      bit          finished;
      logic [31:0] held;
      logic [4:0]  first;
      beat_t       e;
      s        = v.sel;
      hold     = 0;
      cyc      = 0;
      finished = 1'b0;
      held     = '0;
      for (int r = 0; r < 32; r++) begin
         pre[r] = (r == 0) ? 32'd0 : ((v.pat == 0) ? 32'h1000_0000 + 32'(r) : $urandom);
      end
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      beat_cnt[s]  = 0;
      done_cnt[s]  = 0;
      first_idx[s] = -1;
      first = (s == 1) ? 5'd1 : 5'd0;
      for (int r = int'(first); r < 32; r++) begin
         e = '{idx: 5'(r), data: regs[r], last: (r == 31)};
         push_exp(s, e);
      end
      ready[s] = 1'b1;
      start[s] = 1'b1;
      @(posedge clk); #1;
      start[s] = 1'b0;
      check("read_busy", busy[s], 1);
      check("read_valid_low", dump_valid[s], 0);
      check("read_addr", rd_addr[s], first);
      @(posedge clk); #1;
      check("latency_valid", dump_valid[s], 1);
      while (!finished && cyc < 600) begin
         ready[s] = 1'b1;
         start[s] = 1'b0;
         wr_en    = 1'b0;
         case (v.mode)
            1: ready[s] = 1'($urandom_range(0, 1));
            2: if (dump_valid[s] && dump_index[s] == 5'd7 && hold < 5) begin
               ready[s] = 1'b0;
               if (hold == 0) held = dump_data[s];
               else check("stall_data_held", dump_data[s], held);
               hold++;
            end
            3: begin
               if (busy[s] && !dump_valid[s] && !done[s] && rd_addr[s] == 5'd5) begin
                  wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
               end
               if (dump_valid[s] && dump_index[s] == 5'd9) begin
                  wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234_5678;
               end
            end
            4: if (dump_valid[s] && dump_index[s] == 5'd12) begin
               ready[s] = 1'b0;
               rst = 1'b1;
               #1;
               check("rst_valid", dump_valid[s], 0);
               check("rst_busy", busy[s], 0);
               check("rst_rd_addr", rd_addr[s], 0);
               check("rst_done", done[s], 0);
               check("rst_index", dump_index[s], 0);
               check("rst_data", dump_data[s], 0);
               if (s == 0) exp_q0.delete();
               else exp_q1.delete();
               @(posedge clk); #1;
               rst = 1'b0;
               finished = 1'b1;
            end
            5: if ((dump_valid[s] && dump_index[s] == 5'd10) || done[s]) start[s] = 1'b1;
            default: ;
         endcase
         if (done[s]) finished = 1'b1;
         if (!finished) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      @(posedge clk); #1;
      start[s] = 1'b0;
      wr_en    = 1'b0;
      ready[s] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      if (!finished) begin
         ntests++;
         nfail++;
         $display("FAIL timeout: got no end of dump after %0d cycles, required done", cyc);
      end
      if (v.mode == 2) check("stall_cycles", hold, 5);
      check("beat_count", beat_cnt[s], v.exp_beats);
      check("done_count", done_cnt[s], v.exp_dones);
      check("first_index", first_idx[s], v.exp_first);
      check("queue_empty", qsize(s), 0);
      check("idle_busy", busy[s], 0);
      check("idle_rd_addr", rd_addr[s], 0);
   endtask

   initial begin
      vec_t vecs [9];
      vecs[0] = '{sel: 0, mode: 0, pat: 0, exp_beats: 32, exp_dones: 1, exp_first: 0};
      vecs[1] = '{sel: 1, mode: 0, pat: 0, exp_beats: 31, exp_dones: 1, exp_first: 1};
      vecs[2] = '{sel: 0, mode: 2, pat: 0, exp_beats: 32, exp_dones: 1, exp_first: 0};
      vecs[3] = '{sel: 0, mode: 3, pat: 0, exp_beats: 32, exp_dones: 1, exp_first: 0};
      vecs[4] = '{sel: 0, mode: 4, pat: 1, exp_beats: 12, exp_dones: 0, exp_first: 0};
      vecs[5] = '{sel: 0, mode: 0, pat: 1, exp_beats: 32, exp_dones: 1, exp_first: 0};
      vecs[6] = '{sel: 0, mode: 5, pat: 0, exp_beats: 32, exp_dones: 1, exp_first: 0};
      vecs[7] = '{sel: 0, mode: 1, pat: 1, exp_beats: 32, exp_dones: 1, exp_first: 0};
      vecs[8] = '{sel: 1, mode: 1, pat: 1, exp_beats: 31, exp_dones: 1, exp_first: 1};

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("reset_valid%0d", i), dump_valid[i], 0);
         check($sformatf("reset_busy%0d", i), busy[i], 0);
         check($sformatf("reset_done%0d", i), done[i], 0);
         check($sformatf("reset_rd_addr%0d", i), rd_addr[i], 0);
         check($sformatf("reset_index%0d", i), dump_index[i], 0);
         check($sformatf("reset_data%0d", i), dump_data[i], 0);
         check($sformatf("reset_last%0d", i), dump_last[i], 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      for (int v = 0; v < 9; v++) begin
         run_dump(vecs[v]);
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
